// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RV32I controller:
// opcode values, the 4-bit state encoding and the datapath select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LUI = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADR  = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    SRCA_OLDPC = 2'b00,
    SRCA_A     = 2'b01,
    SRCA_ZERO  = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    WD_ALUOUT = 2'b00,
    WD_MDR    = 2'b01,
    WD_PC     = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    logic        mem_req;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_write_cond_ne;
    logic        pc_source;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    logic        reg_write;
    mem_to_reg_e mem_to_reg;
    logic        instr_done;
    logic        halted;
  } ctrl_word_t;

  // Opcode dispatch out of DECODE; anything unrecognised halts the core.
  function automatic state_e decode_dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_R:               return S_EXEC_R;
      OP_I:               return S_EXEC_I;
      OP_LOAD, OP_STORE:  return S_MEM_ADR;
      OP_BRANCH:          return S_BRANCH;
      OP_JAL:             return S_JAL;
      OP_LUI:             return S_EXEC_LUI;
      default:            return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Control word decode: current state (plus func3 in BRANCH and the memory
// ready qualifier in memory states) to the datapath control word.
module multicycle_ctrl_outdec
  import riscv_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] func3,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  // One case arm per state; everything not set stays 0.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: cw.alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        cw.alu_src_a = SRCA_A;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRCA_A;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_LUI: begin
        cw.alu_src_a = SRCA_ZERO;
        cw.alu_src_b = SRCB_IMM;
      end
      S_ALU_WB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEM_ADR: begin
        cw.alu_src_a = SRCA_A;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WD_MDR;
        cw.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_req    = 1'b1;
        cw.iord       = 1'b1;
        cw.mem_write  = 1'b1;
        cw.instr_done = mem_ready;
      end
      S_BRANCH: begin
        cw.alu_src_a        = SRCA_A;
        cw.alu_op           = ALUOP_SUB;
        cw.pc_source        = 1'b1;
        cw.pc_write_cond    = (func3 == F3_BEQ);
        cw.pc_write_cond_ne = (func3 == F3_BNE);
        cw.instr_done       = (func3 == F3_BEQ) || (func3 == F3_BNE);
      end
      S_JAL: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = 1'b1;
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WD_PC;
        cw.instr_done = 1'b1;
      end
      S_HALT:  cw.halted = 1'b1;
      default: cw.halted = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I controller: state register, next-state logic and
// memory handshake qualification. Outputs come from the state only.
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  FETCH      | read instruction at PC, PC <= PC+4 on ready
//  DECODE     | ALUOut <= OldPC+imm, dispatch on opcode
//  EXEC_R     | ALU on A,B with func decode
//  EXEC_I     | ALU on A,imm with func decode
//  EXEC_LUI   | ALU passes 0+imm
//  ALU_WB     | write ALUOut to rd, retire
//  MEM_ADR    | ALUOut <= A+imm
//  MEM_RD     | load request at ALUOut, wait for ready
//  MEM_WB     | write MDR to rd, retire
//  MEM_WR     | store request at ALUOut, retire on ready
//  BRANCH     | compare A-B, conditional PC <= ALUOut
//  JAL        | PC <= ALUOut, rd <= PC, retire
//  HALT       | illegal instruction, left only by reset
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ir_opcode,
  input  logic [2:0] ir_func3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCond_NE,
  output logic       PCSource,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic       instr_done,
  output logic       halted
);

  state_e     state;
  logic       active;
  logic       ready_eff;
  ctrl_word_t cw_raw;
  ctrl_word_t cw;

  assign ready_eff = MEM_HS ? mem_ready : 1'b1;

  // State register and transitions; 'active' keeps all outputs low for the
  // first cycle after reset release so the first request appears one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active) begin
        case (state)
          S_FETCH:    if (ready_eff) state <= S_DECODE;
          S_DECODE:   state <= decode_dispatch(ir_opcode);
          S_EXEC_R,
          S_EXEC_I,
          S_EXEC_LUI: state <= S_ALU_WB;
          S_ALU_WB,
          S_MEM_WB,
          S_JAL:      state <= S_FETCH;
          S_MEM_ADR:  state <= (ir_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
          S_MEM_RD:   if (ready_eff) state <= S_MEM_WB;
          S_MEM_WR:   if (ready_eff) state <= S_FETCH;
          S_BRANCH:   state <= ((ir_func3 == F3_BEQ) || (ir_func3 == F3_BNE)) ? S_FETCH : S_HALT;
          S_HALT:     state <= S_HALT;
          default:    state <= S_HALT;
        endcase
      end
    end
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (state),
    .func3     (ir_func3),
    .mem_ready (ready_eff),
    .cw        (cw_raw)
  );

  assign cw = active ? cw_raw : '0;

  assign mem_req        = cw.mem_req;
  assign IorD           = cw.iord;
  assign MemWrite       = cw.mem_write;
  assign IRWrite        = cw.ir_write;
  assign PCWrite        = cw.pc_write;
  assign PCWriteCond    = cw.pc_write_cond;
  assign PCWriteCond_NE = cw.pc_write_cond_ne;
  assign PCSource       = cw.pc_source;
  assign ALUSrcA        = cw.alu_src_a;
  assign ALUSrcB        = cw.alu_src_b;
  assign ALUOp          = cw.alu_op;
  assign RegWrite       = cw.reg_write;
  assign MemtoReg       = cw.mem_to_reg;
  assign instr_done     = cw.instr_done;
  assign halted         = cw.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level timeline model (phases of
// fixed or wait-stretched length with their expected controls) checked cycle
// by cycle against one handshaking and one non-handshaking instance.
module tb_multicycle_ctrl;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef struct packed {
    logic       mem_req, iord, mem_write, ir_write, pc_write, pc_cond, pc_cond_ne, pc_source;
    logic [1:0] src_a, src_b, alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       instr_done, halted;
  } cw_t;

  typedef struct {
    cw_t base;
    cw_t last;
    bit  mem;
    int  waits;
  } phase_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] op1 = OPC_R, op0 = OPC_R;
  logic [2:0] f31 = 3'd0, f30 = 3'd0;
  logic rdy1 = 1'b0;

  logic d1_req, d1_iord, d1_mw, d1_irw, d1_pcw, d1_pcc, d1_pcne, d1_pcs, d1_rw, d1_done, d1_halt;
  logic [1:0] d1_sa, d1_sb, d1_op, d1_m2r;
  logic d0_req, d0_iord, d0_mw, d0_irw, d0_pcw, d0_pcc, d0_pcne, d0_pcs, d0_rw, d0_done, d0_halt;
  logic [1:0] d0_sa, d0_sb, d0_op, d0_m2r;

  int checks = 0;
  int passes = 0;
  phase_t ph[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_HS(1'b1)) dut_hs (
    .clk(clk), .rst(rst), .ir_opcode(op1), .ir_func3(f31), .mem_ready(rdy1),
    .mem_req(d1_req), .IorD(d1_iord), .MemWrite(d1_mw), .IRWrite(d1_irw), .PCWrite(d1_pcw),
    .PCWriteCond(d1_pcc), .PCWriteCond_NE(d1_pcne), .PCSource(d1_pcs), .ALUSrcA(d1_sa),
    .ALUSrcB(d1_sb), .ALUOp(d1_op), .RegWrite(d1_rw), .MemtoReg(d1_m2r),
    .instr_done(d1_done), .halted(d1_halt)
  );

  multicycle_ctrl #(.MEM_HS(1'b0)) dut_nohs (
    .clk(clk), .rst(rst), .ir_opcode(op0), .ir_func3(f30), .mem_ready(1'b0),
    .mem_req(d0_req), .IorD(d0_iord), .MemWrite(d0_mw), .IRWrite(d0_irw), .PCWrite(d0_pcw),
    .PCWriteCond(d0_pcc), .PCWriteCond_NE(d0_pcne), .PCSource(d0_pcs), .ALUSrcA(d0_sa),
    .ALUSrcB(d0_sb), .ALUOp(d0_op), .RegWrite(d0_rw), .MemtoReg(d0_m2r),
    .instr_done(d0_done), .halted(d0_halt)
  );

  function automatic cw_t obs(input bit hs);
    if (hs)
      return {d1_req, d1_iord, d1_mw, d1_irw, d1_pcw, d1_pcc, d1_pcne, d1_pcs,
              d1_sa, d1_sb, d1_op, d1_rw, d1_m2r, d1_done, d1_halt};
    return {d0_req, d0_iord, d0_mw, d0_irw, d0_pcw, d0_pcc, d0_pcne, d0_pcs,
            d0_sa, d0_sb, d0_op, d0_rw, d0_m2r, d0_done, d0_halt};
  endfunction

  function automatic void add_ph(input cw_t b, input cw_t l, input bit m, input int w);
    phase_t p;
    p.base = b; p.last = l; p.mem = m; p.waits = w;
    ph.push_back(p);
  endfunction

  // Expected instruction timeline from the architectural description:
  // fetch, decode, then the class-specific steps. Memory phases stretch by
  // their wait count; 'last' controls appear only in a phase's final cycle.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int fw,
                       input int dw, input int hc);
    cw_t z, b, l;
    z = '0;
    ph.delete();
    b = z; b.mem_req = 1; b.src_b = 2'b01;
    l = z; l.ir_write = 1; l.pc_write = 1;
    add_ph(b, l, 1, fw);
    b = z; b.src_b = 2'b10;
    add_ph(b, z, 0, 0);
    case (op)
      OPC_R, OPC_I, OPC_LUI: begin
        b = z;
        if (op == OPC_LUI) begin b.src_a = 2'b10; b.src_b = 2'b10; end
        else begin b.src_a = 2'b01; b.alu_op = 2'b10; if (op == OPC_I) b.src_b = 2'b10; end
        add_ph(b, z, 0, 0);
        b = z; b.reg_write = 1; b.instr_done = 1;
        add_ph(b, z, 0, 0);
      end
      OPC_LD: begin
        b = z; b.src_a = 2'b01; b.src_b = 2'b10; add_ph(b, z, 0, 0);
        b = z; b.mem_req = 1; b.iord = 1; add_ph(b, z, 1, dw);
        b = z; b.reg_write = 1; b.mem_to_reg = 2'b01; b.instr_done = 1; add_ph(b, z, 0, 0);
      end
      OPC_ST: begin
        b = z; b.src_a = 2'b01; b.src_b = 2'b10; add_ph(b, z, 0, 0);
        b = z; b.mem_req = 1; b.iord = 1; b.mem_write = 1;
        l = z; l.instr_done = 1;
        add_ph(b, l, 1, dw);
      end
      OPC_BR: begin
        b = z; b.src_a = 2'b01; b.alu_op = 2'b01; b.pc_source = 1;
        b.pc_cond = (f3 == 3'b000);
        b.pc_cond_ne = (f3 == 3'b001);
        b.instr_done = (f3 == 3'b000) || (f3 == 3'b001);
        add_ph(b, z, 0, 0);
        if (!b.instr_done)
          for (int k = 0; k < hc; k++) begin b = z; b.halted = 1; add_ph(b, z, 0, 0); end
      end
      OPC_JAL: begin
        b = z; b.pc_write = 1; b.pc_source = 1; b.reg_write = 1; b.mem_to_reg = 2'b10;
        b.instr_done = 1;
        add_ph(b, z, 0, 0);
      end
      default:
        for (int k = 0; k < hc; k++) begin b = z; b.halted = 1; add_ph(b, z, 0, 0); end
    endcase
  endtask

  // Drive one instruction and compare every cycle; ready is random outside
  // memory phases (must be ignored) and low for the wait cycles inside them.
  task automatic run_instr(input bit hs, input logic [6:0] op, input logic [2:0] f3,
                           input int fw, input int dw, input int hc, input string name);
    cw_t e, o, z;
    int n;
    z = '0;
    n = 0;
    build(op, f3, fw, dw, hc);
    foreach (ph[i]) begin
      int dur;
      dur = ph[i].mem ? 1 + ph[i].waits : 1;
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        if (hs) begin
          op1 = op; f31 = f3;
          rdy1 = ph[i].mem ? (c == dur - 1) : 1'($urandom_range(0, 1));
        end else begin
          op0 = op; f30 = f3;
        end
        #1;
        e = ph[i].base | ((c == dur - 1) ? ph[i].last : z);
        o = obs(hs);
        n++;
        checks++;
        if (o !== e) $display("FAIL %s cycle %0d: got %h expected %h", name, n, o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs(1) !== '0 || obs(0) !== '0)
      $display("FAIL reset_outputs: got %h / %h expected 0", obs(1), obs(0));
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs(1) !== '0) $display("FAIL reset_release_cycle: got %h expected 0", obs(1));
    else passes++;
  endtask

  task automatic test_alu();
    run_instr(1, 7'h33, 3'd0, 0, 0, 0, "add");
    run_instr(1, OPC_I, 3'd5, 1, 0, 0, "addi_fetch_wait");
    run_instr(1, OPC_LUI, 3'd2, 0, 0, 0, "lui");
  endtask

  task automatic test_load_wait();
    run_instr(1, 7'h03, 3'd2, 0, 2, 0, "lw_wait2");
  endtask

  task automatic test_branch();
    run_instr(1, OPC_BR, 3'b000, 0, 0, 0, "beq");
    run_instr(1, OPC_BR, 3'b001, 0, 0, 0, "bne");
    run_instr(1, OPC_JAL, 3'd0, 0, 0, 0, "jal");
    run_instr(1, OPC_BR, 3'b100, 0, 0, 6, "branch_bad_f3_halt");
  endtask

  task automatic test_store_reset();
    cw_t o;
    test_reset();
    run_instr(1, OPC_ST, 3'd2, 0, 0, 0, "sw");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); op1 = OPC_ST; f31 = 3'd2; rdy1 = 1'b1;
    end
    @(negedge clk);
    rdy1 = 1'b0;
    #1;
    o = obs(1);
    checks++;
    if (!(o.mem_req === 1'b1 && o.iord === 1'b1 && o.mem_write === 1'b1 && o.instr_done === 1'b0))
      $display("FAIL sw_wait_hold: got %h expected req/iord/write set, no done", o);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs(1) !== '0) $display("FAIL sw_reset_drop: got %h expected 0", obs(1));
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    o = obs(1);
    checks++;
    if (!(o.mem_req === 1'b1 && o.iord === 1'b0 && o.mem_write === 1'b0 && o.instr_done === 1'b0))
      $display("FAIL sw_after_reset_fetch: got %h expected fetch request only", o);
    else passes++;
    run_instr(1, OPC_R, 3'd0, 0, 0, 0, "add_after_sw_reset");
  endtask

  task automatic test_random();
    logic [6:0] kinds [8];
    logic [6:0] op;
    logic [2:0] f3;
    kinds = '{OPC_R, OPC_I, OPC_LUI, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_BR};
    for (int k = 0; k < 40; k++) begin
      op = kinds[$urandom_range(0, 7)];
      f3 = (op == OPC_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(1, op, f3, $urandom_range(0, 2), $urandom_range(0, 2), 0, "random");
    end
  endtask

  task automatic test_no_handshake();
    test_reset();
    run_instr(0, OPC_R, 3'd0, 0, 0, 0, "nohs_add");
    run_instr(0, OPC_LD, 3'd2, 0, 0, 0, "nohs_lw");
    run_instr(0, OPC_ST, 3'd2, 0, 0, 0, "nohs_sw");
    run_instr(0, 7'h7F, 3'd0, 0, 0, 5, "nohs_illegal_halt");
    test_reset();
    run_instr(0, OPC_JAL, 3'd0, 0, 0, 0, "nohs_jal_after_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_store_reset();
    test_random();
    test_no_handshake();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
